// File: rtl/mc_pkg.sv
// Shared encodings, state enum and control-word layout for the multi-cycle MIPS controller.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  // Must match the existing ALU decoder.
  localparam logic [1:0] ALU_ZERO = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;
  localparam logic [1:0] ALU_OR   = 2'b11;

  localparam logic [1:0] SRCA_PC   = 2'b00;
  localparam logic [1:0] SRCA_REG  = 2'b01;
  localparam logic [1:0] SRCA_ZERO = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  localparam logic [1:0] EXT_ZERO  = 2'b00;
  localparam logic [1:0] EXT_SIGN  = 2'b01;
  localparam logic [1:0] EXT_UPPER = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_R_WB, S_EXEC_I, S_I_WB, S_MEM_ADDR,
    S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_ILLEGAL
  } state_t;

  typedef struct packed {
    logic [1:0] alu_op;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] ext_op;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       halted;
  } ctrl_t;

  // Final state of every legal instruction; leaving it retires the instruction.
  function automatic logic is_retire_state(input state_t s);
    return s inside {S_R_WB, S_I_WB, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP};
  endfunction

endpackage

// File: rtl/mc_ctrl_out.sv
// Combinational state -> control-word decoder.
// MC_CTRL_ILLEGAL_TRAP_EN makes ILLEGAL raise halted.
module mc_ctrl_out
  import mc_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       z,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.ir_write = 1'b1;
        ctrl.src_a    = SRCA_PC;
        ctrl.src_b    = SRCB_FOUR;
        ctrl.alu_op   = ALU_ADD;
        ctrl.pc_src   = PCSRC_ALU;
        ctrl.pc_write = 1'b1;
      end
      // Branch target is precomputed into ALUOut while the opcode is decoded.
      S_DECODE: begin
        ctrl.src_a  = SRCA_PC;
        ctrl.src_b  = SRCB_BOFF;
        ctrl.alu_op = ALU_ADD;
        ctrl.ext_op = EXT_SIGN;
      end
      S_EXEC_R: begin
        ctrl.src_a = SRCA_REG;
        ctrl.src_b = SRCB_REG;
        case (funct)
          FN_ADDU: ctrl.alu_op = ALU_ADD;
          FN_SUBU: ctrl.alu_op = ALU_SUB;
          default: ctrl.alu_op = ALU_ZERO;
        endcase
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      // lui is an OR of zero with imm<<16.
      S_EXEC_I: begin
        ctrl.src_a  = (opcode == OP_LUI) ? SRCA_ZERO : SRCA_REG;
        ctrl.src_b  = SRCB_IMM;
        ctrl.ext_op = (opcode == OP_LUI) ? EXT_UPPER : EXT_ZERO;
        ctrl.alu_op = ALU_OR;
      end
      S_I_WB: ctrl.reg_write = 1'b1;
      S_MEM_ADDR: begin
        ctrl.src_a  = SRCA_REG;
        ctrl.src_b  = SRCB_IMM;
        ctrl.ext_op = EXT_SIGN;
        ctrl.alu_op = ALU_ADD;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WR: ctrl.mem_write = 1'b1;
      S_BRANCH: begin
        ctrl.src_a    = SRCA_REG;
        ctrl.src_b    = SRCB_REG;
        ctrl.alu_op   = ALU_SUB;
        ctrl.pc_src   = PCSRC_ALUOUT;
        ctrl.pc_write = z;
      end
      S_JUMP: begin
        ctrl.pc_src   = PCSRC_JUMP;
        ctrl.pc_write = 1'b1;
      end
      S_ILLEGAL: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        ctrl.halted = 1'b1;
`endif
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM with retired-instruction counter.
// MC_CTRL_ILLEGAL_TRAP_EN turns ILLEGAL into a terminal halt state; otherwise it is a NOP.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             z,
  output logic [1:0]       ALUop,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       ext_op,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             ir_write,
  output logic             mem_write,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic [CNT_W-1:0] retired,
  output logic             halted
);

  state_t state;
  state_t next_state;
  ctrl_t  ctrl;
  logic   retire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:      next_state = S_EXEC_R;
          OP_ORI, OP_LUI: next_state = S_EXEC_I;
          OP_LW, OP_SW:  next_state = S_MEM_ADDR;
          OP_BEQ:        next_state = S_BRANCH;
          OP_J:          next_state = S_JUMP;
          default:       next_state = S_ILLEGAL;
        endcase
      end
      S_EXEC_R:   next_state = S_R_WB;
      S_EXEC_I:   next_state = S_I_WB;
      S_MEM_ADDR: next_state = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   next_state = S_MEM_WB;
      S_R_WB, S_I_WB, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP:
                  next_state = S_FETCH;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      S_ILLEGAL:  next_state = S_ILLEGAL;
`else
      S_ILLEGAL:  next_state = S_FETCH;
`endif
      default:    next_state = S_FETCH;
    endcase
  end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  assign retire = is_retire_state(state);
`else
  assign retire = is_retire_state(state) || (state == S_ILLEGAL);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       retired <= '0;
    else if (retire) retired <= retired + CNT_W'(1);
  end

  mc_ctrl_out u_out (
    .state  (state),
    .opcode (opcode),
    .funct  (funct),
    .z      (z),
    .ctrl   (ctrl)
  );

  // Reset forces FETCH, whose enables must not reach the datapath until reset drops.
  assign pc_write   = ctrl.pc_write  & ~reset;
  assign ir_write   = ctrl.ir_write  & ~reset;
  assign mem_write  = ctrl.mem_write & ~reset;
  assign reg_write  = ctrl.reg_write & ~reset;
  assign ALUop      = ctrl.alu_op;
  assign alu_src_a  = ctrl.src_a;
  assign alu_src_b  = ctrl.src_b;
  assign ext_op     = ctrl.ext_op;
  assign pc_src     = ctrl.pc_src;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign halted     = ctrl.halted;

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: per-cycle hand-written control words are queued, a monitor checks them.
module tb_mc_ctrl;

  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             z;
  logic [1:0]       ALUop, alu_src_a, alu_src_b, ext_op, pc_src;
  logic             pc_write, ir_write, mem_write, reg_write, reg_dst, mem_to_reg, halted;
  logic [CNT_W-1:0] retired;

  mc_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .z(z),
    .ALUop(ALUop), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_op(ext_op),
    .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .mem_write(mem_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .retired(retired), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            tag;
    logic [16:0]      word;
    logic [CNT_W-1:0] ret;
  } exp_t;

  exp_t             scb[$];
  int               tests  = 0;
  int               failed = 0;
  logic [CNT_W-1:0] exp_ret = '0;

  // {ALUop, src_a, src_b, ext_op, pc_write, pc_src, ir_write, mem_write, reg_write, reg_dst, mem_to_reg, halted}
  function automatic logic [16:0] cw(input logic [1:0] alu, input logic [1:0] sa,
                                     input logic [1:0] sb, input logic [1:0] ext,
                                     input logic pcw, input logic [1:0] pcs,
                                     input logic irw, input logic mw, input logic rw,
                                     input logic rd, input logic m2r, input logic h);
    return {alu, sa, sb, ext, pcw, pcs, irw, mw, rw, rd, m2r, h};
  endfunction

  always @(negedge clk) begin
    if (scb.size() > 0) begin
      exp_t        e;
      logic [16:0] act;
      e   = scb.pop_front();
      act = {ALUop, alu_src_a, alu_src_b, ext_op, pc_write, pc_src, ir_write,
             mem_write, reg_write, reg_dst, mem_to_reg, halted};
      tests++;
      if (act !== e.word) begin
        failed++;
        $display("FAIL %s ctrl: got %05h required %05h", e.tag, act, e.word);
      end
      tests++;
      if (retired !== e.ret) begin
        failed++;
        $display("FAIL %s retired: got %0d required %0d", e.tag, retired, e.ret);
      end
    end
  end

  task automatic ex(input string tag, input logic [16:0] w);
    scb.push_back('{tag, w, exp_ret});
  endtask

  task automatic ex_reset(input string tag);
    ex(tag, cw(2'b01, 2'b00, 2'b01, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic start(input logic [5:0] op, input logic [5:0] fn, input logic zv);
    opcode = op; funct = fn; z = zv;
    ex("fetch",  cw(2'b01, 2'b00, 2'b01, 2'b00, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    ex("decode", cw(2'b01, 2'b00, 2'b11, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic run(input int n, input bit ret);
    if (ret) exp_ret = exp_ret + 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_r(input logic [5:0] fn, input logic [1:0] alu, input string tag);
    start(6'h00, fn, 1'b0);
    ex(tag,    cw(alu,   2'b01, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    ex("r_wb", cw(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    run(4, 1'b1);
  endtask

  task automatic do_i(input logic [5:0] op, input logic [1:0] sa, input logic [1:0] ext,
                      input string tag);
    start(op, 6'h00, 1'b1);
    ex(tag,    cw(2'b11, sa,    2'b10, ext,   1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    ex("i_wb", cw(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    run(4, 1'b1);
  endtask

  task automatic do_beq(input logic zv);
    start(6'h04, 6'h00, zv);
    ex(zv ? "beq_taken" : "beq_not", cw(2'b10, 2'b01, 2'b00, 2'b00, zv, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    run(3, 1'b1);
  endtask

  task automatic do_j();
    start(6'h02, 6'h15, 1'b0);
    ex("jump", cw(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    run(3, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    failed++;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; opcode = 6'h00; funct = 6'h21; z = 1'b0;
    ex_reset("in_reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // addu interrupted by reset in DECODE: must not retire.
    start(6'h00, 6'h21, 1'b0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    exp_ret = '0;
    ex_reset("reset_mid_decode");
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;

    do_r(6'h21, 2'b01, "exec_addu");
    do_r(6'h23, 2'b10, "exec_subu");
    do_r(6'h25, 2'b00, "exec_unknown_funct");
    do_i(6'h0d, 2'b01, 2'b00, "exec_ori");
    do_i(6'h0f, 2'b10, 2'b10, "exec_lui");

    start(6'h23, 6'h00, 1'b0);
    ex("lw_addr",  cw(2'b01, 2'b01, 2'b10, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    ex("lw_memrd", cw(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    ex("lw_memwb", cw(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
    run(5, 1'b1);

    start(6'h2b, 6'h00, 1'b1);
    ex("sw_addr",  cw(2'b01, 2'b01, 2'b10, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    ex("sw_memwr", cw(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    run(4, 1'b1);

    do_beq(1'b1);
    do_beq(1'b0);
    do_j();

    // Retired counter (3 bits) has wrapped past 7 by now.
    start(6'h3f, 6'h00, 1'b0);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    repeat (4) ex("illegal_halt", cw(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    run(6, 1'b0);
    reset = 1'b1;
    exp_ret = '0;
    ex_reset("halt_reset");
    @(posedge clk);
    #1 reset = 1'b0;
`else
    ex("illegal_nop", cw(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    run(3, 1'b1);
`endif
    do_j();
    do_r(6'h21, 2'b01, "exec_addu_final");

    repeat (2) @(posedge clk);
    tests++;
    if (scb.size() != 0) begin
      failed++;
      $display("FAIL drain: %0d entries left, required 0", scb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
